bird_column: RTL and testbench
==============================

Name: bird_column

Overview:
- Parametrised successor to the single-cell bird light. One block now owns the whole vertical LED column holding the bird.
- Tracks bird row; one-hot LED vector drives the bird column of the LED matrix.
- Rising edge of the flap key → bird rises FLAP_HEIGHT rows on the next game tick; otherwise it falls one row per tick.
- Detects floor hit and pipe collision; sticky crash output feeds the game-over logic.

Parameters:
- ROWS, 16, column height in LEDs (≥2); row 0 = bottom.
- START_ROW, 8, row loaded on reset (< ROWS).
- FLAP_HEIGHT, 2, rows gained per flap (1..ROWS-1).
- RW, $clog2(ROWS), row index width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low (0 = reset).
- enable  in  1  game tick strobe, one clk wide.
- gameOver  in  1  freeze: position, pending flap and crash hold while 1.
- up  in  1  flap key level, already synchronised, 1 = pressed.
- pipe_mask  in  ROWS  pipe occupancy of the bird's column, bit i = row i.
- lights  out  ROWS  one-hot bird LED vector.
- row  out  RW  current bird row.
- crash  out  1  sticky collision flag.

Behaviour:
- Reset (reset==0 at posedge): row=START_ROW, lights=1<<START_ROW, crash=0, flap_pending=0, up_d=0. Reset overrides all other inputs, including gameOver and a crash in progress.
- Edge detect: up_d <= up every clk, including during gameOver. A flap edge is up & ~up_d.
- Flap latch:
  - A flap edge with no tick that cycle sets flap_pending.
  - Multiple edges between ticks collapse to one flap.
  - Edges while gameOver==1 or crash==1 are ignored.
- Tick (enable==1, gameOver==0, crash==0):
  - If flap_pending or a flap edge occurs this same cycle: next = min(row+FLAP_HEIGHT, ROWS-1), i.e. saturate at the ceiling. Hitting the ceiling is not a crash. flap_pending clears.
  - Else if row==0: the floor is hit. Row stays 0 and crash sets.
  - Else: next = row-1.
  - Compute row+FLAP_HEIGHT at RW+1 bits before saturating, so there is no wrap-around.
- Pipe collision:
  - Evaluated every clk with gameOver==0: if |(pipe_mask & lights), crash sets on the next edge.
  - Uses the current registered lights, not next.
  - A pipe and a tick in the same cycle: both crash and the move take effect; row updates on that tick, then freezes.
- Crash: sticky until reset. While crash==1, row and lights hold and flap_pending is cleared.
- gameOver==1: all state holds except up_d. Ticks are ignored and nothing accumulates.
- Latency: row, lights and crash change exactly one clk after the qualifying enable or collision cycle.
- lights is registered and always == 1<<row. Exactly one bit is set at all times after reset.
- Outputs carry no combinational path from inputs.

Test Plan:
- Reset & fall (ROWS=16, START_ROW=8, FLAP_HEIGHT=2): hold reset=0 for 2 clk, then release; pulse enable 3 times with up=0 → row 8→7→6→5, lights=0x0020, crash=0.
- Flap & collapse: from row 5, toggle up 0→1→0→1 between ticks, then one enable → row=7 (single flap); next tick with no edge → row=6.
- Ceiling saturation: flap every tick from row 14 → row 15, then stays 15 on the next flap, lights=0x8000, crash=0.
- Floor crash: let the bird fall to row 0; one further enable → crash=1, row=0. Further enables and flaps are ignored. Assert reset → row=8, crash=0.
- Pipe collision: row=6, drive pipe_mask=0x0040 → crash=1 next clk; pipe_mask=0x0080 at row 6 → no crash.
- Freeze: gameOver=1, pulse enable 4 times and press up → row unchanged, no pending flap. Deassert gameOver and tick → bird falls one row (no stale flap).

Source files
------------

// File: rtl/bird_column_if.sv
// bird_column_if: game-side bundle for the bird column block.
//   master: game/testbench side, drives the tick, freeze, flap key and pipe mask; reads the LEDs.
//   slave : bird_column side.
//   enable    tick strobe, one clk wide
//   gameOver  freeze request
//   up        flap key level, already synchronised
//   pipe_mask pipe occupancy of the bird's column, bit i = row i
//   lights    one-hot bird LED vector
//   row       current bird row
//   crash     sticky collision flag
interface bird_column_if #(
  parameter int ROWS = 16,
  parameter int RW   = $clog2(ROWS)
);
  logic            enable;
  logic            gameOver;
  logic            up;
  logic [ROWS-1:0] pipe_mask;
  logic [ROWS-1:0] lights;
  logic [RW-1:0]   row;
  logic            crash;

  modport master (output enable, gameOver, up, pipe_mask,
                  input  lights, row, crash);
  modport slave  (input  enable, gameOver, up, pipe_mask,
                  output lights, row, crash);
endinterface

// File: rtl/bird_column.sv
// bird_column: owns the LED column holding the bird.
//   A rising edge of the flap key lifts the bird FLAP_HEIGHT rows on the
//   next tick (saturating at the top row). Otherwise the bird drops one row
//   per tick. Hitting the floor or overlapping a pipe raises a sticky crash.
//   clk    system clock
//   reset  synchronous, active low
//   bus    bird_column_if.slave (enable, gameOver, up, pipe_mask -> lights, row, crash)
module bird_column #(
  parameter int ROWS        = 16,
  parameter int START_ROW   = 8,
  parameter int FLAP_HEIGHT = 2,
  parameter int RW          = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  bird_column_if.slave  bus
);
  localparam logic [RW:0]   TOP_W  = (RW+1)'(ROWS-1);
  localparam logic [RW-1:0] START  = RW'(START_ROW);
  localparam logic [RW:0]   FLAP_W = (RW+1)'(FLAP_HEIGHT);

  logic [RW-1:0]   row_q;
  logic [ROWS-1:0] lights_q;
  logic            crash_q;
  logic            flap_pending;
  logic            up_d;

  logic            flap_edge;
  logic            live;
  logic            tick;
  logic [RW:0]     flap_sum;
  logic [RW-1:0]   flap_row;
  logic [RW-1:0]   next_row;
  logic            floor_hit;
  logic            pipe_hit;

  assign flap_edge = bus.up & ~up_d;
  assign live      = ~bus.gameOver & ~crash_q;
  assign tick      = bus.enable & live;
  // Checked against the registered lights, so no input reaches an output combinationally.
  assign pipe_hit  = live & (|(bus.pipe_mask & lights_q));

  always_comb begin
    // One extra bit so the add cannot wrap before saturating.
    flap_sum  = {1'b0, row_q} + FLAP_W;
    flap_row  = (flap_sum > TOP_W) ? TOP_W[RW-1:0] : flap_sum[RW-1:0];
    next_row  = row_q;
    floor_hit = 1'b0;
    if (tick) begin
      if (flap_pending || flap_edge) next_row = flap_row;
      else if (row_q == '0)          floor_hit = 1'b1;
      else                           next_row = row_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q        <= START;
      lights_q     <= ROWS'(1) << START;
      crash_q      <= 1'b0;
      flap_pending <= 1'b0;
      up_d         <= 1'b0;
    end else begin
      up_d <= bus.up;
      if (live) begin
        row_q    <= next_row;
        lights_q <= ROWS'(1) << next_row;
        if (floor_hit || pipe_hit) crash_q <= 1'b1;
        if (tick)           flap_pending <= 1'b0;
        else if (flap_edge) flap_pending <= 1'b1;
      end else if (!bus.gameOver) begin
        // Crashed: position holds, any flap caught just before the crash is dropped.
        flap_pending <= 1'b0;
      end
    end
  end

  assign bus.row    = row_q;
  assign bus.lights = lights_q;
  assign bus.crash  = crash_q;
endmodule

// File: tb/tb_bird_column.sv
module tb_bird_column;
  localparam int ROWS = 16;
  localparam int RW   = 4;

  typedef struct packed {
    logic [RW-1:0] row;
    logic          crash;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  bird_column_if #(.ROWS(ROWS)) bus ();

  bird_column #(.ROWS(ROWS), .START_ROW(8), .FLAP_HEIGHT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected post-edge state, then
  // pop and check it 1 time unit after the edge.
  task automatic step(input logic rst, input logic en, input logic go, input logic u,
                      input logic [ROWS-1:0] pm, input logic [RW-1:0] er,
                      input logic ec, input string tag);
    exp_t e;
    logic [ROWS-1:0] el;
    reset         = rst;
    bus.enable    = en;
    bus.gameOver  = go;
    bus.up        = u;
    bus.pipe_mask = pm;
    sb.push_back('{row: er, crash: ec});
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    el = ROWS'(1) << e.row;
    n_assert++;
    assert (bus.row === e.row)
      else begin n_fail++; $error("FAIL %s row: got %0d want %0d", tag, bus.row, e.row); end
    n_assert++;
    assert (bus.lights === el)
      else begin n_fail++; $error("FAIL %s lights: got %h want %h", tag, bus.lights, el); end
    n_assert++;
    assert (bus.crash === e.crash)
      else begin n_fail++; $error("FAIL %s crash: got %b want %b", tag, bus.crash, e.crash); end
  endtask

  task automatic go_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd8, 1'b0, "reset");
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 4'd8, 1'b0, "reset_ovr");
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = 1'b0; bus.gameOver = 1'b0; bus.up = 1'b0; bus.pipe_mask = '0;
    @(posedge clk); #1;

    // Reset and fall 8 -> 5
    go_reset();
    step(1, 1, 0, 0, '0, 4'd7, 0, "fall1");
    step(1, 1, 0, 0, '0, 4'd6, 0, "fall2");
    step(1, 1, 0, 0, '0, 4'd5, 0, "fall3");

    // Two edges between ticks collapse into one flap; tick with up held high
    step(1, 0, 0, 1, '0, 4'd5, 0, "edge1");
    step(1, 0, 0, 0, '0, 4'd5, 0, "edge_lo");
    step(1, 0, 0, 1, '0, 4'd5, 0, "edge2");
    step(1, 1, 0, 1, '0, 4'd7, 0, "flap_once");
    step(1, 1, 0, 0, '0, 4'd6, 0, "no_stale");

    // Flap edge on the tick cycle itself, up to ceiling saturation
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, '0, (i == 0) ? 4'd6 : ((i >= 5) ? 4'd15 : 4'(6 + 2*i)), 0, "ceil_lo");
      step(1, 1, 0, 1, '0, (i >= 4) ? 4'd15 : 4'(8 + 2*i), 0, "ceil_flap");
    end

    // Fall 15 -> 0, then floor crash, then everything ignored
    for (int r = 14; r >= 0; r--)
      step(1, 1, 0, 0, '0, 4'(r), 0, "drop");
    step(1, 1, 0, 0, '0, 4'd0, 1, "floor");
    step(1, 1, 0, 0, '0, 4'd0, 1, "crash_hold");
    step(1, 0, 0, 1, '0, 4'd0, 1, "crash_flap");
    step(1, 1, 0, 0, '0, 4'd0, 1, "crash_tick");
    go_reset();

    // Pipe collision at row 6
    step(1, 1, 0, 0, '0, 4'd7, 0, "to6a");
    step(1, 1, 0, 0, '0, 4'd6, 0, "to6b");
    step(1, 0, 0, 0, 16'h0080, 4'd6, 0, "pipe_miss");
    step(1, 0, 0, 0, 16'h0040, 4'd6, 1, "pipe_hit");
    step(1, 1, 0, 0, '0, 4'd6, 1, "pipe_hold");
    go_reset();

    // Pipe and tick together: move lands, then frozen
    step(1, 1, 0, 0, 16'h0100, 4'd7, 1, "pipe_tick");
    step(1, 1, 0, 0, '0, 4'd7, 1, "pipe_tick_hold");
    go_reset();

    // Pending flap then pipe crash: flap must not resurface after recovery
    step(1, 0, 0, 1, 16'h0100, 4'd8, 1, "pend_crash");
    go_reset();

    // Freeze: ticks, flaps and pipes ignored, no flap remembered
    step(1, 1, 1, 0, '0, 4'd8, 0, "frz_tick1");
    step(1, 1, 1, 0, 16'h0100, 4'd8, 0, "frz_pipe");
    step(1, 0, 1, 1, '0, 4'd8, 0, "frz_edge");
    step(1, 1, 1, 1, '0, 4'd8, 0, "frz_tick2");
    step(1, 1, 1, 0, '0, 4'd8, 0, "frz_tick3");
    step(1, 1, 1, 1, '0, 4'd8, 0, "frz_tick4");
    step(1, 1, 0, 1, '0, 4'd7, 0, "thaw_fall");
    step(1, 1, 0, 0, '0, 4'd6, 0, "thaw_fall2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
